// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM encoding and default sizing.
// The sync/edge stage is also used by other blocks that consume divided clocks.
package period_meter_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_MEASURE    = 2'd1,
    ST_TIMEOUT    = 2'd2
  } state_t;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, followed by a one-flop
// edge history that yields single-cycle rise and fall indications.
module sync_edge_det
  import period_meter_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev   <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev;
  assign fall = ~sync_q[STAGES-1] & prev;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles, with a
// one-cycle valid strobe per input cycle and a loss-of-activity timeout.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The counter saturates instead of wrapping; reaching the top means lost input.
  function automatic logic at_max(input logic [CNT_W-1:0] c);
    return c == CNT_MAX;
  endfunction

  logic rise;
  logic fall;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sig_in),
    .rise    (rise),
    .fall    (fall)
  );

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_cnt_next;
  logic [CNT_W-1:0] period_next;
  logic [CNT_W-1:0] high_time_next;
  logic             valid_next;
  logic             locked_next;
  logic             timeout_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WAIT_FIRST;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    hi_cnt_next    = hi_cnt;
    period_next    = period;
    high_time_next = high_time;
    valid_next     = 1'b0;
    locked_next    = locked;
    timeout_next   = timeout;
    case (state)
      ST_WAIT_FIRST: begin
        if (rise) begin
          state_next  = ST_MEASURE;
          cnt_next    = CNT_ONE;
          hi_cnt_next = '0;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          period_next    = cnt;
          high_time_next = hi_cnt;
          valid_next     = 1'b1;
          locked_next    = 1'b1;
          cnt_next       = CNT_ONE;
          hi_cnt_next    = '0;
        end else begin
          if (fall) begin
            hi_cnt_next = cnt;
          end
          // A rise at the saturated count still wins (handled above).
          if (at_max(cnt)) begin
            state_next   = ST_TIMEOUT;
            timeout_next = 1'b1;
            locked_next  = 1'b0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
      end
      ST_TIMEOUT: begin
        if (rise) begin
          state_next   = ST_MEASURE;
          timeout_next = 1'b0;
          cnt_next     = CNT_ONE;
          hi_cnt_next  = '0;
        end
      end
      default: begin
        state_next = ST_WAIT_FIRST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      hi_cnt    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      hi_cnt    <= hi_cnt_next;
      period    <= period_next;
      high_time <= high_time_next;
      valid     <= valid_next;
      locked    <= locked_next;
      timeout   <= timeout_next;
    end
  end

endmodule
